// File: rtl/trace_pkg.sv
// trace_pkg: constants and types shared by the trace port transmitter.
//   TPIU_FSYNC / TPIU_HSYNC : full-sync frame and halfword sync/padding words
//   W1 / W2 / W4            : legal active bus width encodings
//   tx_state_e              : transmitter FSM state (halfword to load next)
//   tx_ctrl_t               : transmitter control register (FSM state, sync
//                             request and the width the stream is running at)
//   width_legal / last_slice / slice_pair : width-dependent helpers
package trace_pkg;

  localparam logic [31:0] TPIU_FSYNC = 32'h7fff_ffff;
  localparam logic [15:0] TPIU_HSYNC = 16'h7fff;

  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W4 = 3'd4;

  typedef enum logic [1:0] {
    SYNC_LO = 2'd0,
    SYNC_HI = 2'd1,
    DATA    = 2'd2
  } tx_state_e;

  typedef struct packed {
    tx_state_e  state;
    logic       sync_pending;
    logic [2:0] wsel;
  } tx_ctrl_t;

  function automatic logic width_legal(input logic [2:0] w);
    return (w == W1) || (w == W2) || (w == W4);
  endfunction

  // Index of the last slice of a halfword: 16 bits / (2*w) slices.
  function automatic logic [2:0] last_slice(input logic [2:0] w);
    case (w)
      W1:      return 3'd7;
      W2:      return 3'd3;
      W4:      return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  // Returns {b, a}: a = v[w-1:0] (rising half), b = v[2w-1:w] (falling half),
  // each zero-extended to 4 bits.
  function automatic logic [7:0] slice_pair(input logic [15:0] v,
                                            input logic [2:0]  w);
    case (w)
      W1:      return {3'b000, v[1], 3'b000, v[0]};
      W2:      return {2'b00, v[3:2], 2'b00, v[1:0]};
      W4:      return {v[7:4], v[3:0]};
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/trace_tx_serdes.sv
// trace_tx_serdes: 16-bit shift register and slice counter for the trace
// transmitter. Each cycle one slice of 2*w bits leaves LSB first: the low w
// bits on douta (rising half) and the next w bits on doutb (falling half).
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   load           : take word/width this cycle; its first slice is on the
//                    outputs in the next cycle
//   halt           : stop; outputs go to 0 and every cycle becomes a boundary
//   width [2:0]    : width used for the word being loaded
//   word  [15:0]   : halfword to load
//   douta / doutb  : registered DDR slice outputs
//   boundary       : last slice of the current halfword is on the outputs
//                    (or nothing is running), so a load is due now
module trace_tx_serdes
  import trace_pkg::*;
#(
  parameter int BUSWIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                halt,
  input  logic [2:0]          width,
  input  logic [15:0]         word,
  output logic [BUSWIDTH-1:0] douta,
  output logic [BUSWIDTH-1:0] doutb,
  output logic                boundary
);

  logic [15:0]         sr_q;
  logic [2:0]          w_q;
  logic [2:0]          cnt_q;
  logic                run_q;
  logic [15:0]         src;
  logic [15:0]         sr_nxt;
  logic [2:0]          sw;
  logic [7:0]          pair;
  logic [3:0]          a4;
  logic [3:0]          b4;
  logic [BUSWIDTH-1:0] a_bus;
  logic [BUSWIDTH-1:0] b_bus;

  assign boundary = !run_q || (cnt_q == last_slice(w_q));

  // On a load the first slice is cut straight from the incoming word so the
  // output register never shows a gap between halfwords.
  always_comb begin
    src    = load ? word : sr_q;
    sw     = load ? width : w_q;
    pair   = slice_pair(src, sw);
    sr_nxt = src >> {sw, 1'b0};
  end

  assign a4 = pair[3:0];
  assign b4 = pair[7:4];

  generate
    if (BUSWIDTH > 4) begin : g_wide
      assign a_bus = {{(BUSWIDTH-4){1'b0}}, a4};
      assign b_bus = {{(BUSWIDTH-4){1'b0}}, b4};
    end else begin : g_narrow
      assign a_bus = a4[BUSWIDTH-1:0];
      assign b_bus = b4[BUSWIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q  <= '0;
      w_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      douta <= '0;
      doutb <= '0;
    end else if (load) begin
      sr_q  <= sr_nxt;
      w_q   <= width;
      cnt_q <= '0;
      run_q <= 1'b1;
      douta <= a_bus;
      doutb <= b_bus;
    end else if (halt || !run_q) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      douta <= '0;
      doutb <= '0;
    end else begin
      sr_q  <= sr_nxt;
      cnt_q <= cnt_q + 3'd1;
      douta <= a_bus;
      doutb <= b_bus;
    end
  end

endmodule

// File: rtl/trace_tx.sv
// trace_tx: serialises 16-bit packet words onto a 1/2/4-bit DDR trace bus in
// TPIU-Lite framing. Full-sync frames (ffff then 7fff, LSB first) are sent
// after reset, after every width change and every SYNC_INTERVAL data
// halfwords; 7fff padding fills idle halfwords.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   width [2:0]           : active bus width 1, 2 or 4 (others invalid)
//   WdValid, PacketWd     : word offered by the packet source
//   WdReady               : word accepted this cycle (see handshake note)
//   traceDouta/traceDoutb : rising/falling half bits for the DDR cells
//   inSync                : a full-sync frame is on the outputs
// Optional build macro TRACE_TX_STATS_EN adds wordCount[31:0] (accepted
// words) and syncCount[15:0] (sync frames started), both wrap-around.
//
// Handshake: WdReady is combinational and high only on a halfword boundary
// in DATA with no sync due and an unchanged legal width; it never depends on
// WdValid. A word moves when WdValid && WdReady at a rising edge, PacketWd is
// sampled only then, and its first bits are on the outputs the next cycle.
// The source must hold WdValid and PacketWd until accepted.
module trace_tx
  import trace_pkg::*;
#(
  parameter int BUSWIDTH      = 4,
  parameter int SYNC_INTERVAL = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          width,
  input  logic                WdValid,
  input  logic [15:0]         PacketWd,
  output logic                WdReady,
  output logic [BUSWIDTH-1:0] traceDouta,
  output logic [BUSWIDTH-1:0] traceDoutb,
  output logic                inSync
`ifdef TRACE_TX_STATS_EN
  ,
  output logic [31:0]         wordCount,
  output logic [15:0]         syncCount
`endif
);

  localparam int SCW = (SYNC_INTERVAL > 1) ? $clog2(SYNC_INTERVAL) : 1;
  localparam logic [SCW-1:0] SYNC_RELOAD = SCW'(SYNC_INTERVAL - 1);

  tx_ctrl_t       ctrl_q;
  tx_ctrl_t       ctrl_d;
  tx_state_e      ld_state;
  logic [SCW-1:0] sync_cnt;
  logic           boundary;
  logic           width_ok;
  logic           load;
  logic           halt;
  logic           ready;
  logic [15:0]    word;

  assign width_ok = width_legal(width) && (32'(width) <= BUSWIDTH);

  // Control register: state names the halfword to load at the next boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '{state: SYNC_LO, sync_pending: 1'b0, wsel: 3'd0};
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    ld_state = ctrl_q.state;
    load     = 1'b0;
    halt     = 1'b0;
    ready    = 1'b0;
    word     = TPIU_HSYNC;
    if (boundary) begin
      ctrl_d.wsel = width;
      if (!width_ok) begin
        // Park in SYNC_LO with quiet outputs until a legal width returns.
        halt         = 1'b1;
        ctrl_d.state = SYNC_LO;
      end else begin
        load = 1'b1;
        // A width change or an expired sync interval overrides the queue,
        // so a waiting word stays put while the frame goes out.
        if ((width != ctrl_q.wsel) ||
            ((ctrl_q.state == DATA) && ctrl_q.sync_pending)) begin
          ld_state = SYNC_LO;
        end
        case (ld_state)
          SYNC_LO: begin
            word                = TPIU_FSYNC[15:0];
            ctrl_d.state        = SYNC_HI;
            ctrl_d.sync_pending = 1'b0;
          end
          SYNC_HI: begin
            word         = TPIU_FSYNC[31:16];
            ctrl_d.state = DATA;
          end
          default: begin
            ready        = 1'b1;
            word         = WdValid ? PacketWd : TPIU_HSYNC;
            ctrl_d.state = DATA;
            if (sync_cnt == '0) begin
              ctrl_d.sync_pending = 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign WdReady = ready;

  // Counts DATA halfwords (words and padding) down to the next forced sync.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_cnt <= SYNC_RELOAD;
    end else if (load) begin
      if (ld_state == SYNC_LO) begin
        sync_cnt <= SYNC_RELOAD;
      end else if ((ld_state == DATA) && (sync_cnt != '0)) begin
        sync_cnt <= sync_cnt - SCW'(1);
      end
    end
  end

  // Registered alongside the data outputs so it covers exactly the cycles a
  // sync halfword is on the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inSync <= 1'b0;
    end else if (load) begin
      inSync <= (ld_state != DATA);
    end else if (halt) begin
      inSync <= 1'b0;
    end
  end

  trace_tx_serdes #(
    .BUSWIDTH (BUSWIDTH)
  ) u_serdes (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .halt     (halt),
    .width    (width),
    .word     (word),
    .douta    (traceDouta),
    .doutb    (traceDoutb),
    .boundary (boundary)
  );

`ifdef TRACE_TX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wordCount <= '0;
      syncCount <= '0;
    end else begin
      if (WdValid && ready) begin
        wordCount <= wordCount + 32'd1;
      end
      if (load && (ld_state == SYNC_LO)) begin
        syncCount <= syncCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trace_tx.sv
// tb_trace_tx: directed bench for trace_tx with a TPIU-Lite receiver model.
// Words accepted by the DUT are queued in exp_q and checked in order as the
// receiver model decodes them from traceDouta/traceDoutb.
module tb_trace_tx;

  localparam int BW = 4;
  localparam logic [31:0] FSYNC = 32'h7fff_ffff;
  localparam logic [15:0] HSYNC = 16'h7fff;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [2:0]    width = 3'd4;
  logic          WdValid = 1'b0;
  logic [15:0]   PacketWd = 16'h0000;
  logic          WdReady;
  logic [BW-1:0] traceDouta;
  logic [BW-1:0] traceDoutb;
  logic          inSync;
`ifdef TRACE_TX_STATS_EN
  logic [31:0]   wordCount;
  logic [15:0]   syncCount;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_sent = 0;
  int n_rcv = 0;
  int n_sync = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [15:0] exp_q[$];

  // Expected first eight samples after reset release at width 4.
  logic [3:0] t_a [8] = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf};
  logic [3:0] t_b [8] = '{4'hf, 4'hf, 4'hf, 4'h7, 4'hf, 4'h7, 4'hf, 4'h7};

  trace_tx #(
    .BUSWIDTH      (BW),
    .SYNC_INTERVAL (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .width      (width),
    .WdValid    (WdValid),
    .PacketWd   (PacketWd),
    .WdReady    (WdReady),
    .traceDouta (traceDouta),
    .traceDoutb (traceDoutb),
    .inSync     (inSync)
`ifdef TRACE_TX_STATS_EN
    ,
    .wordCount  (wordCount),
    .syncCount  (syncCount)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- receiver model / scoreboard ----------------
  logic [31:0] m_hist = '0;
  logic [15:0] m_hw = '0;
  int          m_bc = 0;
  bit          m_synced = 0;
  logic [2:0]  m_last_w = 3'd0;

  task automatic got_word(input logic [15:0] w);
    logic [15:0] e;
    n_rcv++;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL rx_unexpected: observed %0h expected none", w);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("rx_word", {16'h0, w}, {16'h0, e});
    end
  endtask

  task automatic rx_bit(input logic b);
    m_hist = {b, m_hist[31:1]};
    if (m_synced) begin
      m_hw = {b, m_hw[15:1]};
      m_bc++;
      if (m_bc == 16) begin
        m_bc = 0;
        if (m_hw != HSYNC && m_hw != 16'hffff) got_word(m_hw);
      end
    end
    if (m_hist == FSYNC) begin
      m_synced = 1;
      m_bc = 0;
      n_sync++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_hist = '0;
      m_hw = '0;
      m_bc = 0;
      m_synced = 0;
    end else begin
      if (width != m_last_w) begin
        m_synced = 0;
        m_hist = '0;
      end
      m_last_w = width;
      if (width == 3'd1 || width == 3'd2 || width == 3'd4) begin
        for (int i = 0; i < 2 * int'(width); i++) begin
          if (i < int'(width)) rx_bit(traceDouta[i]);
          else rx_bit(traceDoutb[i - int'(width)]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] w);
    int n = 0;
    PacketWd = w;
    WdValid = 1'b1;
    #1;
    while (!WdReady && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("send_ready", {31'h0, WdReady}, 32'd1);
    if (WdReady) begin
      exp_q.push_back(w);
      n_sent++;
      acc_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic sync_len(input string tag, input int exp_len);
    int d = 0;
    while (inSync && d < 40) begin
      d++;
      @(negedge clk);
    end
    check(tag, 32'(d), 32'(exp_len));
  endtask

  function automatic logic [15:0] rnd_word();
    return 16'($urandom_range(16'h0001, 16'h7ffe));
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int prev;
    int gmin;
    int gmax;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_douta", 32'(traceDouta), 32'd0);
    check("rst_doutb", 32'(traceDoutb), 32'd0);
    check("rst_insync", {31'h0, inSync}, 32'd0);
    check("rst_ready", {31'h0, WdReady}, 32'd0);
`ifdef TRACE_TX_STATS_EN
    check("rst_wordcount", wordCount, 32'd0);
    check("rst_synccount", {16'h0, syncCount}, 32'd0);
`endif

    // start-up sync at width 4, then padding with a periodic sync
    rst = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n <= 8) begin
        check("boot_douta", 32'(traceDouta), 32'(t_a[n-1]));
        check("boot_doutb", 32'(traceDoutb), 32'(t_b[n-1]));
      end
      check("boot_ready", {31'h0, WdReady},
            {31'h0, (n % 2 == 0) && n >= 4 && n != 20 && n != 22});
      check("boot_insync", {31'h0, inSync},
            {31'h0, n <= 4 || (n >= 21 && n <= 24)});
    end

    // width 2, two words back-to-back
    width = 3'd2;
    send(16'h1234);
    send(16'hABCD);
    WdValid = 1'b0;
    drain();

    // continuous stream across a forced sync
    gmin = 1000;
    gmax = 0;
    prev = -1;
    for (int i = 0; i < 12; i++) begin
      send(rnd_word());
      if (prev >= 0) begin
        if (acc_cyc - prev < gmin) gmin = acc_cyc - prev;
        if (acc_cyc - prev > gmax) gmax = acc_cyc - prev;
      end
      prev = acc_cyc;
    end
    WdValid = 1'b0;
    check("stream_gap_min", 32'(gmin), 32'd4);
    check("stream_gap_max", 32'(gmax), 32'd12);
    drain();

    // width 4 traffic, then 4 -> 1 change on a data boundary
    width = 3'd4;
    send(rnd_word());
    send(rnd_word());
    WdValid = 1'b0;
    drain();
    k = 0;
    #1;
    while (!(WdReady && !inSync) && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("w1_boundary_found", {31'h0, WdReady}, 32'd1);
    width = 3'd1;
    @(negedge clk);
    check("w1_sync_start", {31'h0, inSync}, 32'd1);
    check("w1_sync_douta", 32'(traceDouta), 32'd1);
    sync_len("w1_sync_len", 16);
    for (int i = 0; i < 3; i++) send(rnd_word());
    WdValid = 1'b0;
    drain();

    // invalid width parks the bus; restoring it starts with a sync frame
    width = 3'd3;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check("w3_douta", 32'(traceDouta), 32'd0);
      check("w3_doutb", 32'(traceDoutb), 32'd0);
      check("w3_ready", {31'h0, WdReady}, 32'd0);
      check("w3_insync", {31'h0, inSync}, 32'd0);
      @(negedge clk);
    end
    width = 3'd2;
    k = 0;
    while (!inSync && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("w2_resync", {31'h0, inSync}, 32'd1);
    check("w2_resync_douta", 32'(traceDouta), 32'd3);
    check("w2_resync_doutb", 32'(traceDoutb), 32'd3);
    sync_len("w2_sync_len", 8);
    send(16'h0F0F);
    send(16'h3C5A);
    WdValid = 1'b0;
    drain();

    // reset in the middle of a width-1 word
    width = 3'd1;
    send(16'h5555);
    WdValid = 1'b0;
    @(negedge clk);
    check("pre_reset_douta", 32'(traceDouta), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_douta", 32'(traceDouta), 32'd0);
    check("mid_rst_doutb", 32'(traceDoutb), 32'd0);
    check("mid_rst_insync", {31'h0, inSync}, 32'd0);
    check("mid_rst_ready", {31'h0, WdReady}, 32'd0);
    repeat (2) @(negedge clk);
`ifdef TRACE_TX_STATS_EN
    check("mid_rst_wordcount", wordCount, 32'd0);
    check("mid_rst_synccount", {16'h0, syncCount}, 32'd0);
`endif
    rst = 1'b1;
    n_sent = 0;
    n_rcv = 0;
    @(negedge clk);
    check("post_rst_insync", {31'h0, inSync}, 32'd1);
    check("post_rst_douta", 32'(traceDouta), 32'd1);
    check("post_rst_doutb", 32'(traceDoutb), 32'd1);
    send(rnd_word());
    send(rnd_word());
    WdValid = 1'b0;
    drain();

    // final report
    check("rcv_count", 32'(n_rcv), 32'(n_sent));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/trace_tx.md
Name: trace_tx

Overview:
- Transmit-side counterpart of the trace port receiver. Serialises 16-bit packet words onto a 1/2/4-bit DDR trace bus in TPIU-Lite framing.
- Inserts full-sync frames (32'h7fff_ffff) at start-up, on a width change and periodically.
- Emits 16'h7fff halfword padding when no data is offered.
- Sits between the packet source (test pattern / loopback generator) and the output DDR cells that drive TRACEDATA.

Parameters:
- BUSWIDTH, 4, physical trace bus width in bits (max usable width).
- SYNC_INTERVAL, 1024, halfwords sent between forced full-sync frames (>=4).

Ports:
- clk  in  1  system clock; trace clock output is generated from it externally.
- rst  in  1  asynchronous, active-low reset.
- width  in  3  active bus width (1, 2 or 4); 0, 3 and >4 are invalid.
- WdValid  in  1  PacketWd holds a word to send.
- PacketWd  in  16  next packet word.
- WdReady  out  1  block accepts PacketWd this cycle.
- traceDouta  out  BUSWIDTH  bits for the rising-edge half of the trace clock.
- traceDoutb  out  BUSWIDTH  bits for the falling-edge half of the trace clock.
- inSync  out  1  high while a full-sync frame is on the outputs.

Behaviour:
- Reset (rst low, async):
  - traceDouta, traceDoutb, WdReady and inSync = 0.
  - State = SYNC_LO.
  - Bit counter = 0.
  - Sync counter = SYNC_INTERVAL-1.
- Serialisation:
  - A 16-bit shift register is transmitted LSB first.
  - Each cycle, traceDouta[w-1:0] = sr[w-1:0] and traceDoutb[w-1:0] = sr[2w-1:w], where w = width.
  - Output bits at or above w are 0.
  - sr shifts right by 2w per cycle.
  - A halfword takes 8/4/2 cycles for w = 1/2/4.
  - Outputs are registered.
- Halfword boundary:
  - The boundary is the last slice cycle of the current halfword.
  - At the boundary, the next halfword is selected and loaded, so output is continuous with no gap cycles.
- States, with the halfword loaded on entry:
  - SYNC_LO loads 16'hffff, then goes to SYNC_HI.
  - SYNC_HI loads 16'h7fff, then goes to DATA.
  - DATA loads PacketWd if WdValid, else 16'h7fff padding.
  - Sending 16'hffff then 16'h7fff LSB first presents 32'h7fff_ffff with MSB latest, matching the receiver's comparison.
- Handshake:
  - WdReady is combinationally high only on a boundary cycle with state DATA and no sync pending.
  - A transfer occurs when WdValid && WdReady.
  - The word's first bits appear on the outputs in the following cycle.
  - WdValid must be held until accepted. PacketWd is sampled only on transfer.
- Sync counter:
  - Decrements once per halfword sent in DATA.
  - At zero, sync_pending is set. At the next boundary, state goes to SYNC_LO instead of loading data (WdReady low), and the counter reloads.
- Simultaneous events: if the counter expires on the same boundary where WdValid is high, sync wins and the word waits.
- Data words equal to 16'h7fff are transmitted unchanged; the receiver discards them. Sources must avoid them.
- Width change:
  - width is sampled only at boundaries. A changed value forces SYNC_LO at that boundary, with the bit counter cleared.
  - An invalid width forces the outputs to 0 and WdReady to 0, holding SYNC_LO. A full sync starts once width is valid again.
- inSync is high for every cycle in which SYNC_LO or SYNC_HI bits are being output.
- Reset mid-word: the word in flight is lost and the outputs go to 0 immediately.

Optional Feature:
- TRACE_TX_STATS_EN, when defined:
  - Adds outputs wordCount[31:0] (accepted data words) and syncCount[15:0] (sync frames sent).
  - Both are wrap-around counters, cleared by reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package trace_pkg holds:
  - TPIU_FSYNC = 32'h7fff_ffff
  - TPIU_HSYNC = 16'h7fff
  - the width encodings (W1 = 1, W2 = 2, W4 = 4)
  - the state enum (SYNC_LO, SYNC_HI, DATA)
- One natural sub-module, trace_tx_serdes: the 16-bit shift register plus slice counter, with load/boundary strobes and width input. The FSM and handshake stay in trace_tx.

Test Plan:
- Release reset, width=4, WdValid=0 -> after 1 cycle, 4 cycles show ffff/7fff with inSync=1, then continuous 7fff padding and WdReady pulsing every 2 cycles.
- width=2, stream words 0x1234, 0xABCD back-to-back -> the receiver model outputs 0x1234 then 0xABCD. WdReady accepts one word per 4 cycles with no idle slices.
- SYNC_INTERVAL=8, continuous WdValid -> after 8 data halfwords WdReady stays low for 2 boundaries, a ffff/7fff frame is sent, and data resumes with no word lost or duplicated.
- Change width 4->1 mid-stream -> the change takes effect at the next boundary, a sync frame follows at 8 cycles per halfword, and the receiver resyncs and decodes the subsequent words.
- width=3 -> outputs 0, WdReady 0. Restoring width=2 -> a sync frame is sent first.
- Assert rst low mid-word with width=1 -> outputs are 0 asynchronously. After release, the sequence restarts with a sync frame. With TRACE_TX_STATS_EN, both counters read 0.
